// File: rtl/seg7_reader_if.sv
// Seven-segment reader bus: sample strobe and pattern in, decoded digit handshake out.
interface seg7_reader_if;
    logic       sample_en;
    logic [6:0] leds;
    logic [3:0] bcd;
    logic       bcd_valid;
    logic       bcd_ready;
    logic       bad_code;
    logic       overrun;

    // Producer side: drives the display samples and accepts results
    modport master (
        output sample_en, leds, bcd_ready,
        input  bcd, bcd_valid, bad_code, overrun
    );

    // Reader side
    modport slave (
        input  sample_en, leds, bcd_ready,
        output bcd, bcd_valid, bad_code, overrun
    );
endinterface

// File: rtl/seg7_reader.sv
// Seven-segment reader: debounces an active-low segment pattern, decodes a
// stable pattern to BCD once per change, and presents it over a valid/ready
// handshake with a sticky overrun flag for results dropped while one is pending.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    seg7_reader_if.slave  bus
);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [3:0] STAB  = 4'(STABLE_CYCLES);

    typedef enum logic {TRACK, LOCKED} state_t;

    state_t     r_state, w_state_nxt;
    logic [6:0] r_last_pat;
    logic [6:0] r_rep_pat;
    logic [3:0] r_stab_cnt, w_stab_nxt;
    logic [3:0] r_bcd;
    logic       r_bcd_valid;
    logic       r_bad_code;
    logic       r_overrun;
    logic       w_changed;
    logic       w_accept;
    logic       w_issue;
    logic [3:0] w_dec;

    // Active-low g..a pattern to digit; anything unrecognised maps to F
    function automatic logic [3:0] f_decode(input logic [6:0] p);
        case (p)
            7'b1000000: f_decode = 4'd0;
            7'b1111001: f_decode = 4'd1;
            7'b0100100: f_decode = 4'd2;
            7'b0110000: f_decode = 4'd3;
            7'b0011001: f_decode = 4'd4;
            7'b0010010: f_decode = 4'd5;
            7'b0000010: f_decode = 4'd6;
            7'b1111000: f_decode = 4'd7;
            7'b0000000: f_decode = 4'd8;
            7'b0010000: f_decode = 4'd9;
            default:    f_decode = 4'hF;
        endcase
    endfunction

    assign w_dec = f_decode(bus.leds);

    // Stability counting and accept decision; a change while locked can be
    // accepted on the same sample when a single sample is enough
    always_comb begin
        w_stab_nxt  = r_stab_cnt;
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_changed   = (bus.leds != r_rep_pat);
        if (bus.sample_en) begin
            if (bus.leds == r_last_pat)
                w_stab_nxt = (r_stab_cnt < STAB) ? r_stab_cnt + 4'd1 : r_stab_cnt;
            else
                w_stab_nxt = 4'd1;
            if ((r_state == TRACK || w_changed) && w_stab_nxt == STAB) begin
                w_accept    = 1'b1;
                w_state_nxt = LOCKED;
                w_issue     = (bus.leds != BLANK);
            end else if (r_state == LOCKED && w_changed) begin
                w_state_nxt = TRACK;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= TRACK;
        else          r_state <= w_state_nxt;
    end

    // Sample history: last pattern, run count, last reported pattern
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_pat <= BLANK;
            r_rep_pat  <= BLANK;
            r_stab_cnt <= 4'd0;
        end else if (bus.sample_en) begin
            r_last_pat <= bus.leds;
            r_stab_cnt <= w_stab_nxt;
            if (w_accept) r_rep_pat <= bus.leds;
        end
    end

    // Result handshake: load when the slot is free or being consumed, else flag overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bcd       <= 4'd0;
            r_bcd_valid <= 1'b0;
            r_bad_code  <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_issue) begin
            if (!r_bcd_valid || bus.bcd_ready) begin
                r_bcd       <= w_dec;
                r_bad_code  <= (w_dec == 4'hF);
                r_bcd_valid <= 1'b1;
            end else begin
                r_overrun   <= 1'b1;
            end
        end else if (bus.bcd_ready) begin
            r_bcd_valid <= 1'b0;
        end
    end

    assign bus.bcd       = r_bcd;
    assign bus.bcd_valid = r_bcd_valid;
    assign bus.bad_code  = r_bad_code;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: two instances (4-sample and 1-sample stability) share
// stimulus; each is compared every cycle against a run-length reference model.
module tb_seg7_reader;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_reader_if bus4();
    seg7_reader_if bus1();

    seg7_reader #(.STABLE_CYCLES(4)) dut4 (.clk(clk), .reset_n(rst_n), .bus(bus4));
    seg7_reader #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] dig [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference state per instance: a pattern is accepted when its run of
    // consecutive identical samples reaches exactly S
    int         m_s   [2] = '{4, 1};
    logic [6:0] m_last[2];
    int         m_run [2];
    logic       m_v   [2];
    logic [3:0] m_bcd [2];
    logic       m_bad [2];
    logic       m_ovr [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_dec(input logic [6:0] p);
        ref_dec = 4'hF;
        for (int i = 0; i < 10; i++)
            if (dig[i] == p) ref_dec = 4'(i);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_last[k] = BLANK; m_run[k] = 0;
            m_v[k] = 1'b0; m_bcd[k] = 4'd0; m_bad[k] = 1'b0; m_ovr[k] = 1'b0;
        end
    endtask

    task automatic model_step(input logic se, input logic [6:0] l, input logic rdy);
        logic issue;
        for (int k = 0; k < 2; k++) begin
            issue = 1'b0;
            if (se) begin
                if (l == m_last[k]) begin
                    if (m_run[k] < 100) m_run[k]++;
                end else begin
                    m_last[k] = l;
                    m_run[k]  = 1;
                end
                issue = (m_run[k] == m_s[k]) && (l != BLANK);
            end
            if (issue && (!m_v[k] || rdy)) begin
                m_v[k]   = 1'b1;
                m_bcd[k] = ref_dec(l);
                m_bad[k] = (ref_dec(l) == 4'hF);
            end else if (issue) begin
                m_ovr[k] = 1'b1;
            end else if (rdy) begin
                m_v[k] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/S4 valid"},   32'(bus4.bcd_valid), 32'(m_v[0]));
        chk({tag, "/S4 bcd"},     32'(bus4.bcd),       32'(m_bcd[0]));
        chk({tag, "/S4 bad"},     32'(bus4.bad_code),  32'(m_bad[0]));
        chk({tag, "/S4 overrun"}, 32'(bus4.overrun),   32'(m_ovr[0]));
        chk({tag, "/S1 valid"},   32'(bus1.bcd_valid), 32'(m_v[1]));
        chk({tag, "/S1 bcd"},     32'(bus1.bcd),       32'(m_bcd[1]));
        chk({tag, "/S1 bad"},     32'(bus1.bad_code),  32'(m_bad[1]));
        chk({tag, "/S1 overrun"}, 32'(bus1.overrun),   32'(m_ovr[1]));
    endtask

    task automatic drive(input logic se, input logic [6:0] l, input logic rdy);
        bus4.sample_en = se; bus4.leds = l; bus4.bcd_ready = rdy;
        bus1.sample_en = se; bus1.leds = l; bus1.bcd_ready = rdy;
    endtask

    // One clock: inputs set at the falling edge, outputs checked at the next one
    task automatic step(input string tag, input logic se, input logic [6:0] l, input logic rdy);
        drive(se, l, rdy);
        @(posedge clk);
        model_step(se, l, rdy);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic hold(input string tag, input logic [6:0] l, input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(tag, 1'b1, l, rdy);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, BLANK, 1'b0);
        model_reset();
        @(negedge clk);
        do_reset("reset");

        // Stable 3 reported once, one cycle after the 4th sample
        hold("r029", 7'b0110000, 4, 1'b1);
        chk("r029 valid after 4th", 32'(bus4.bcd_valid), 32'd1);
        chk("r029 bcd is 3", 32'(bus4.bcd), 32'd3);
        hold("r029 hold", 7'b0110000, 4, 1'b1);
        chk("r029 no repeat", 32'(bus4.bcd_valid), 32'd0);

        // Alternating patterns never settle, then 5 settles
        for (int i = 0; i < 8; i++)
            step("r030 alt", 1'b1, (i % 2 == 0) ? 7'b0100100 : 7'b0010010, 1'b1);
        hold("r030 settle", 7'b0010010, 6, 1'b1);

        // Pending 7 blocks 9, overrun sticks
        hold("r031 seven", 7'b1111000, 5, 1'b0);
        hold("r031 nine", 7'b0010000, 6, 1'b0);
        chk("r031 held 7", 32'(bus4.bcd), 32'd7);
        chk("r031 overrun", 32'(bus4.overrun), 32'd1);
        hold("r031 consume", 7'b0010000, 1, 1'b1);
        hold("r031 after", 7'b0010000, 3, 1'b0);
        chk("r031 9 dropped", 32'(bus4.bcd_valid), 32'd0);

        // Non-digit pattern reported as F, blank never reported
        hold("r032 bad", 7'b0001111, 5, 1'b1);
        hold("r032 blank", BLANK, 6, 1'b0);

        // Same digit reported again after an intervening blank
        hold("r033 a", 7'b0000000, 5, 1'b1);
        hold("r033 blank", BLANK, 5, 1'b1);
        hold("r033 b", 7'b0000000, 5, 1'b1);

        // Reset mid-window with a pending result
        hold("r034 pend", 7'b1111000, 5, 1'b0);
        hold("r034 part", 7'b1111001, 2, 1'b0);
        do_reset("r034 reset");
        hold("r034 fresh", 7'b1111001, 3, 1'b0);
        chk("r034 not yet", 32'(bus4.bcd_valid), 32'd0);
        hold("r034 fresh", 7'b1111001, 2, 1'b0);
        chk("r034 reported 1", 32'(bus4.bcd), 32'd1);

        // Randomised runs of digits, blank and junk with gappy strobes
        for (int r = 0; r < 600; r++) begin
            int sel;
            int len;
            logic [6:0] p;
            sel = $urandom_range(0, 12);
            len = $urandom_range(1, 6);
            if (sel < 10)       p = dig[sel];
            else if (sel == 10) p = BLANK;
            else if (sel == 11) p = 7'b0001111;
            else                p = 7'($urandom);
            for (int i = 0; i < len; i++)
                step("rand", ($urandom_range(0, 3) != 0), p, 1'($urandom));
            if (r == 300) do_reset("rand reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
